// File: rtl/vpd_transfer_engine_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vpd_pkg
// Description : Shared types and constants for the VPD transfer engine.
// Revision    : 1.0 - initial release
// ============================================================================
package vpd_pkg;

    localparam int VPD_ADDR_W = 14;
    localparam int VPD_DATA_W = 32;

    // F-bit encoding of the transfer direction
    localparam logic VPD_DIR_READ  = 1'b0;
    localparam logic VPD_DIR_WRITE = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } vpd_state_e;

endpackage
`default_nettype wire

// File: rtl/vpd_transfer_engine_if.sv
`default_nettype none
// ============================================================================
// Module      : vpd_transfer_engine_if
// Description : req/ack bus between the VPD transfer engine and the VPD
//               backing store. master = engine, slave = backing store.
// Revision    : 1.0 - initial release
// ============================================================================
interface vpd_transfer_engine_if
    import vpd_pkg::*;
#(
    parameter int ADDR_WIDTH = VPD_ADDR_W,
    parameter int DATA_WIDTH = VPD_DATA_W
);

    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-2:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_ack;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_err;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_ack,
        input  mem_rdata,
        input  mem_err
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_ack,
        output mem_rdata,
        output mem_err
    );

endinterface
`default_nettype wire

// File: rtl/vpd_transfer_engine.sv
`default_nettype none
// ============================================================================
// Module      : vpd_transfer_engine
// Description : Runs one dword read or write against the VPD backing store
//               per start pulse, owns the VPD Data register and reports
//               completion, backing-store errors and ack timeouts.
// Revision    : 1.0 - initial release
// ============================================================================
module vpd_transfer_engine
    import vpd_pkg::*;
#(
    parameter int ADDR_WIDTH     = VPD_ADDR_W,
    parameter int DATA_WIDTH     = VPD_DATA_W,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] vpd_address,
    input  logic                  transfer_direction,
    input  logic [DATA_WIDTH-1:0] data_write_data,
    input  logic                  data_write_enable,
    output logic [DATA_WIDTH-1:0] data_read_data,
    output logic                  transfer_complete,
    output logic                  busy,
    output logic                  mem_err_flag,
    output logic                  timeout_flag,
    vpd_transfer_engine_if.master mem
);

    localparam int               CNT_W      = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    vpd_state_e            r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [ADDR_WIDTH-2:0] r_addr;
    logic                  r_we;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_req;
    logic                  r_busy;
    logic                  r_cmpl;
    logic                  r_merr;
    logic                  r_tout;

    // The byte-address LSB below the dword boundary never reaches the store
    logic w_unused_addr_lsb;
    assign w_unused_addr_lsb = vpd_address[0];

    // Transfer FSM with timeout counter, address/direction/data captures and Data register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_data  <= '0;
            r_req   <= 1'b0;
            r_busy  <= 1'b0;
            r_cmpl  <= 1'b0;
            r_merr  <= 1'b0;
            r_tout  <= 1'b0;
        end else begin
            r_cmpl <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (data_write_enable) begin
                        r_data <= data_write_data;
                    end
                    if (start) begin
                        r_addr  <= vpd_address[ADDR_WIDTH-1:1];
                        r_we    <= transfer_direction;
                        // Snapshot of the pre-write Data value: a same-cycle
                        // config write lands after the capture.
                        r_wdata <= r_data;
                        r_merr  <= 1'b0;
                        r_tout  <= 1'b0;
                        r_cnt   <= '0;
                        r_req   <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= ACCESS;
                    end
                end
                ACCESS: begin
                    // An ack in the last counted cycle takes priority over timeout
                    if (mem.mem_ack) begin
                        if (mem.mem_err) begin
                            r_merr <= 1'b1;
                        end else if (r_we == VPD_DIR_READ) begin
                            r_data <= mem.mem_rdata;
                        end
                        r_req   <= 1'b0;
                        r_cmpl  <= 1'b1;
                        r_state <= DONE;
                    end else if (r_cnt == C_CNT_LAST) begin
                        // Give up silently: no completion so the F bit stays put
                        r_tout  <= 1'b1;
                        r_req   <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_req   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign data_read_data    = r_data;
    assign transfer_complete = r_cmpl;
    assign busy              = r_busy;
    assign mem_err_flag      = r_merr;
    assign timeout_flag      = r_tout;

    assign mem.mem_req   = r_req;
    assign mem.mem_we    = r_we;
    assign mem.mem_addr  = r_addr;
    assign mem.mem_wdata = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_vpd_transfer_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_vpd_transfer_engine
// Description : Randomized self-checking bench for vpd_transfer_engine with a
//               transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vpd_transfer_engine;
    import vpd_pkg::*;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [13:0] vpd_address;
    logic        transfer_direction;
    logic [31:0] data_write_data;
    logic        data_write_enable;
    logic [31:0] data_read_data;
    logic        transfer_complete;
    logic        busy;
    logic        mem_err_flag;
    logic        timeout_flag;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [31:0] model_data;
    logic        model_merr;
    logic        model_tout;

    vpd_transfer_engine_if #(.ADDR_WIDTH(14), .DATA_WIDTH(32)) mif ();

    vpd_transfer_engine #(
        .ADDR_WIDTH    (14),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .vpd_address       (vpd_address),
        .transfer_direction(transfer_direction),
        .data_write_data   (data_write_data),
        .data_write_enable (data_write_enable),
        .data_read_data    (data_read_data),
        .transfer_complete (transfer_complete),
        .busy              (busy),
        .mem_err_flag      (mem_err_flag),
        .timeout_flag      (timeout_flag),
        .mem               (mif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start             = 1'b0;
        data_write_enable = 1'b0;
        mif.mem_ack       = 1'b0;
        mif.mem_err       = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_req"}, mif.mem_req, 0);
        chk({tag, "_cmpl"}, transfer_complete, 0);
        chk({tag, "_data"}, data_read_data, model_data);
        chk({tag, "_merr"}, mem_err_flag, model_merr);
        chk({tag, "_tout"}, timeout_flag, model_tout);
    endtask

    // Idle cycles, optional config write in the first one, optional stray acks
    task automatic gap(input int n, input bit wr, input logic [31:0] wd, input bit spur);
        for (int i = 0; i < n; i++) begin
            if (wr && i == 0) begin
                data_write_enable = 1'b1;
                data_write_data   = wd;
            end
            if (spur) begin
                mif.mem_ack   = 1'($urandom_range(0, 1));
                mif.mem_rdata = $urandom;
                mif.mem_err   = 1'($urandom_range(0, 1));
            end
            tick();
            if (wr && i == 0) model_data = wd;
            idle_inputs();
            check_idle("gap");
        end
    endtask

    // One transfer; k = ack cycle (1..T), anything else means the store never answers
    task automatic run_xfer(input logic [13:0] addr, input logic dir, input int k,
                            input logic err, input logic [31:0] rdata,
                            input bit same_dwe, input logic [31:0] new_data,
                            input bit collide);
        logic [31:0] exp_wdata;
        bit          tmo;
        bit          exp_req;
        int          last;
        tmo  = (k < 1) || (k > T);
        last = tmo ? T : k + 1;

        start              = 1'b1;
        vpd_address        = addr;
        transfer_direction = dir;
        exp_wdata          = model_data;
        if (same_dwe) begin
            data_write_enable = 1'b1;
            data_write_data   = new_data;
        end
        tick();
        if (same_dwe) model_data = new_data;
        idle_inputs();

        for (int c = 1; c <= last + 1; c++) begin
            exp_req = tmo ? (c <= T) : (c <= k);
            if (!tmo && c == k + 1 && dir == VPD_DIR_READ && !err) model_data = rdata;
            chk("req", mif.mem_req, exp_req);
            chk("busy", busy, c <= last);
            chk("cmpl", transfer_complete, !tmo && c == k + 1);
            chk("data", data_read_data, model_data);
            chk("merr", mem_err_flag, !tmo && err && c > k);
            chk("tout", timeout_flag, tmo && c > T);
            if (exp_req) begin
                chk("addr", mif.mem_addr, addr[13:1]);
                chk("we", mif.mem_we, dir);
                chk("wdata", mif.mem_wdata, exp_wdata);
            end
            if (c <= last) begin
                if (!tmo && c == k) begin
                    mif.mem_ack   = 1'b1;
                    mif.mem_err   = err;
                    mif.mem_rdata = rdata;
                end else if (!tmo && c == k + 1 && $urandom_range(0, 1) == 1) begin
                    mif.mem_ack   = 1'b1;
                    mif.mem_err   = 1'($urandom_range(0, 1));
                    mif.mem_rdata = $urandom;
                end
                if (collide) begin
                    start              = 1'($urandom_range(0, 1));
                    vpd_address        = 14'($urandom);
                    transfer_direction = 1'($urandom_range(0, 1));
                    data_write_enable  = 1'($urandom_range(0, 1));
                    data_write_data    = $urandom;
                end
            end
            tick();
            idle_inputs();
        end
        model_merr = !tmo && err;
        model_tout = tmo;
    endtask

    initial begin
        rst                = 1'b1;
        vpd_address        = '0;
        transfer_direction = 1'b0;
        data_write_data    = '0;
        mif.mem_rdata      = '0;
        idle_inputs();
        model_data = '0;
        model_merr = 1'b0;
        model_tout = 1'b0;

        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_req", mif.mem_req, 0);
        chk("rst_we", mif.mem_we, 0);
        chk("rst_addr", mif.mem_addr, 0);
        chk("rst_cmpl", transfer_complete, 0);
        chk("rst_merr", mem_err_flag, 0);
        chk("rst_tout", timeout_flag, 0);
        chk("rst_data", data_read_data, 0);
        rst = 1'b0;
        tick();

        // Directed: read, write, timeout, error ack, collisions
        run_xfer(14'h0010, VPD_DIR_READ, 3, 1'b0, 32'hDEADBEEF, 0, '0, 0);
        gap(2, 1, 32'h12345678, 0);
        run_xfer(14'h0123, VPD_DIR_WRITE, 1, 1'b0, 32'hCAFEF00D, 0, '0, 0);
        gap(2, 0, '0, 0);
        run_xfer(14'h0042, VPD_DIR_READ, 0, 1'b0, '0, 0, '0, 0);
        gap(1, 0, '0, 0);
        run_xfer(14'h0044, VPD_DIR_READ, T, 1'b0, 32'hA5A5A5A5, 0, '0, 0);
        gap(1, 0, '0, 0);
        run_xfer(14'h0200, VPD_DIR_READ, 2, 1'b1, 32'h0BADF00D, 0, '0, 0);
        gap(1, 0, '0, 0);
        run_xfer(14'h1FFE, VPD_DIR_WRITE, 6, 1'b0, '0, 1, 32'h55AA55AA, 1);
        gap(2, 0, '0, 1);

        // Randomized transactions
        for (int n = 0; n < 150; n++) begin
            run_xfer(14'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, T + 2),
                     1'($urandom_range(0, 3) == 0), $urandom,
                     $urandom_range(0, 3) == 0, $urandom, $urandom_range(0, 1) == 1);
            gap($urandom_range(1, 3), $urandom_range(0, 1) == 1, $urandom,
                $urandom_range(0, 1) == 1);
        end

        // Reset in the second ACCESS cycle, then a late ack must be ignored
        start              = 1'b1;
        vpd_address        = 14'h0ABC;
        transfer_direction = VPD_DIR_WRITE;
        tick();
        idle_inputs();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_data = '0;
        model_merr = 1'b0;
        model_tout = 1'b0;
        chk("mrst_we", mif.mem_we, 0);
        chk("mrst_addr", mif.mem_addr, 0);
        check_idle("mrst");
        mif.mem_ack   = 1'b1;
        mif.mem_rdata = 32'hFFFFFFFF;
        tick();
        idle_inputs();
        check_idle("mrst_ack");
        tick();
        check_idle("mrst_post");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vpd_transfer_engine.md
# vpd_transfer_engine

Downstream stage of the VPD address register. It accepts a start pulse with the latched VPD address and F-bit direction, then runs one dword read or write against the VPD backing store over a req/ack handshake. It owns the 32-bit VPD Data register and pulses `transfer_complete` back to the address register so the F bit flips. A timeout guards against a backing store that never acknowledges.

## Interface
- `ADDR_WIDTH`, 14: width of `vpd_address`; holds byte-address bits [14:1].
- `DATA_WIDTH`, 32: VPD Data register and backing-store data width.
- `TIMEOUT_CYCLES`, 1024: maximum cycles spent waiting for `mem_ack`; must be ≥ 2.
- `clk` input 1: single clock; all logic on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: one-cycle pulse when software writes the VPD Address register.
- `vpd_address` input ADDR_WIDTH: latched VPD address from the address register.
- `transfer_direction` input 1: F bit; 0 = read, 1 = write.
- `data_write_data` input DATA_WIDTH: config write data for the VPD Data register.
- `data_write_enable` input 1: config write strobe for the VPD Data register.
- `data_read_data` output DATA_WIDTH: current VPD Data register contents.
- `transfer_complete` output 1: one-cycle pulse on a successful or errored completion.
- `busy` output 1: high whenever a transfer is in progress.
- `mem_err_flag` output 1: sticky; the backing store returned an error.
- `timeout_flag` output 1: sticky; no ack arrived within TIMEOUT_CYCLES.
- `mem_req` output 1: request to the backing store; held until ack.
- `mem_we` output 1: write qualifier; valid while `mem_req` is high.
- `mem_addr` output ADDR_WIDTH-1: dword index, equal to `vpd_address[ADDR_WIDTH-1:1]`.
- `mem_wdata` output DATA_WIDTH: write data, equal to the VPD Data register.
- `mem_ack` input 1: backing-store completion; valid only while `mem_req` is high.
- `mem_rdata` input DATA_WIDTH: read data, valid with `mem_ack`.
- `mem_err` input 1: error qualifier, valid with `mem_ack`.

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE, on `start`:
  - capture address and direction into internal registers; `mem_addr`, `mem_we` and `mem_wdata` are driven from these captures.
  - clear both sticky flags and the timeout counter, then go to ACCESS.
- ACCESS: `mem_req` = 1 and the counter increments every cycle.
  - `mem_ack` with `mem_err` = 0: on a read, load `mem_rdata` into the Data register. Go to DONE.
  - `mem_ack` with `mem_err` = 1: set `mem_err_flag` and leave the Data register unchanged. Go to DONE.
  - Counter reaches TIMEOUT_CYCLES-1 with no ack: set `timeout_flag` and go to IDLE with no `transfer_complete` pulse, so F is not flipped.
- DONE: `transfer_complete` = 1 for exactly one cycle, then go to IDLE.
- `busy` = (state != IDLE).
- `start` while busy is ignored; the captured address and direction are unchanged.
- `data_write_enable` while busy is ignored. In IDLE it loads `data_write_data` on the next edge.
- `start` and `data_write_enable` in the same IDLE cycle: the Data register takes the new value, but the captured `mem_wdata` is the old value. Software must write data before the address.
- `mem_ack` outside ACCESS is ignored.

## Timing
- Reset values: state IDLE; `busy`, `mem_req`, `mem_we`, `transfer_complete`, both flags = 0; Data register = 0; `mem_addr` = 0.
- Reset mid-transfer: on the next edge everything returns to its reset value, `mem_req` drops, and no completion pulse is issued.
- `start` at cycle 0:
  - `mem_req` rises at cycle 1.
  - Ack at cycle k (k ≥ 1): `mem_req` low at k+1; `data_read_data` updated at k+1; `transfer_complete` high at k+1; `busy` low at k+2.
  - Best-case turnaround is 3 cycles from `start` to IDLE.
- Timeout: if no ack arrives, `mem_req` is high for exactly TIMEOUT_CYCLES cycles (cycles 1 to TIMEOUT_CYCLES). `timeout_flag` and `busy` = 0 take effect at TIMEOUT_CYCLES+1.
- Ack in the final counted cycle wins over timeout.
- Counter width is $clog2(TIMEOUT_CYCLES); it never wraps, because it is cleared on `start`.

## Structure
- Shared package `vpd_pkg`:
  - `vpd_state_e` enum (IDLE, ACCESS, DONE).
  - `VPD_ADDR_W` = 14 and `VPD_DATA_W` = 32.
  - Direction localparams `VPD_DIR_READ` = 0 and `VPD_DIR_WRITE` = 1.
- No sub-module; the FSM, timeout counter and Data register are a single module.
- The top level connects `transfer_complete` to the address register's completion input.

## Test plan
- Read: Data register 0, `start` with address 14'h0010 and F=0; ack at cycle 3 with `mem_rdata` 32'hDEADBEEF → `mem_addr` 13'h0008, `mem_we` 0; `data_read_data` = DEADBEEF and `transfer_complete` pulse at cycle 4; `busy` low at cycle 5.
- Write: Data register = 32'h12345678, `start` with F=1 and immediate ack → `mem_we` 1, `mem_wdata` 12345678, single `transfer_complete` pulse at cycle 2.
- Timeout with TIMEOUT_CYCLES=8 and no ack → `mem_req` high for cycles 1–8, `timeout_flag` set at cycle 9, no `transfer_complete` pulse; the next `start` clears the flag.
- Error ack with `mem_err`=1 on a read → `mem_err_flag` 1, Data register unchanged, `transfer_complete` still pulses.
- Collisions during ACCESS: `start` and `data_write_enable` asserted → both ignored; `mem_addr`, `mem_wdata` and the Data register stay stable.
- `rst` asserted at cycle 2 of ACCESS → all outputs at reset values next cycle; a later ack is ignored and no pulse is issued.
